msk_and_hpc3_pipe: RTL and testbench

// - W-bit vectorised HPC3 masked AND gadget with valid/ready handshakes on data, randomness and output.
// - Owns the one-cycle-delayed copy of share a; callers no longer supply an ina_prev sharing.
// - Output register stage stalls under backpressure without losing or re-masking data.
// - Used by the S-box datapath of the next cores; d-share, order d-1, PINI.

---
 rtl/msk_and_hpc3_pipe_pkg.sv | 29 ++
 rtl/msk_and_hpc3_pipe_if.sv | 38 +++
 rtl/msk_and_hpc3_pipe_lane.sv | 65 ++++++
 rtl/msk_and_hpc3_pipe.sv | 80 ++++++++
 tb/tb_msk_and_hpc3_pipe.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/msk_and_hpc3_pipe_pkg.sv
// ---------------------------------------------------------------------------
// msk_and_hpc3_pipe_pkg
// Purpose : shared sizing and index helpers for the HPC3 masked AND gadget.
//           hpc3rnd(d)   - fresh random bits needed per lane (d*(d-1))
//           npairs(d)    - unordered share pairs (i<j) per lane
//           pair_idx()   - maps an ordered share pair (i,j) onto its
//                          unordered pair slot, so r_ij and r_ji share a bit.
// Ports   : none (package)
// ---------------------------------------------------------------------------
package msk_and_hpc3_pipe_pkg;

    function automatic int hpc3rnd(input int d);
        return d * (d - 1);
    endfunction

    function automatic int npairs(input int d);
        return (d * (d - 1)) / 2;
    endfunction

    // Row-major enumeration of the strict upper triangle of a d x d matrix.
    function automatic int pair_idx(input int i, input int j, input int d);
        int lo;
        int hi;
        lo = (i < j) ? i : j;
        hi = (i < j) ? j : i;
        return lo * d - (lo * (lo + 1)) / 2 + (hi - lo - 1);
    endfunction

endpackage

// File: rtl/msk_and_hpc3_pipe_if.sv
// ---------------------------------------------------------------------------
// msk_and_hpc3_pipe_if
// Purpose : bundles the data, randomness and result handshakes of the
//           masked AND gadget.
// Signals : in_valid/in_ready + ina/inb  (share-major, bit b of share s at
//           [s*W+b]); rnd_valid/rnd_ready + rnd (lane b at
//           [b*hpc3rnd +: hpc3rnd]); out_valid/out_ready + out.
// Modports: master = producer/consumer side, slave = gadget side.
// ---------------------------------------------------------------------------
interface msk_and_hpc3_pipe_if
    import msk_and_hpc3_pipe_pkg::*;
#(
    parameter int D = 2,
    parameter int W = 8
);
    localparam int RND_W = W * hpc3rnd(D);

    logic             in_valid;
    logic             in_ready;
    logic [D*W-1:0]   ina;
    logic [D*W-1:0]   inb;
    logic             rnd_valid;
    logic             rnd_ready;
    logic [RND_W-1:0] rnd;
    logic             out_valid;
    logic             out_ready;
    logic [D*W-1:0]   out;

    modport master (
        output in_valid, ina, inb, rnd_valid, rnd, out_ready,
        input  in_ready, rnd_ready, out_valid, out
    );

    modport slave (
        input  in_valid, ina, inb, rnd_valid, rnd, out_ready,
        output in_ready, rnd_ready, out_valid, out
    );
endinterface

// File: rtl/msk_and_hpc3_pipe_lane.sv
// ---------------------------------------------------------------------------
// msk_and_hpc3_lane
// Purpose : one bit-lane of the HPC3 masked AND. On en_i it latches, for each
//           ordered share pair i!=j, u=(~a_i&r0_ij)^r1_ij and v=b_j^r0_ij,
//           plus a_i and (optionally) a_i&b_i. The output is a pure AND/XOR
//           function of those registers.
// Ports   : clk, rst_n (sync, active low), en_i (load strobe),
//           a_i/b_i (one bit per share), r_i (hpc3rnd(D) fresh bits,
//           low half r0, high half r1), out_o (one bit per share).
// ---------------------------------------------------------------------------
module msk_and_hpc3_lane
    import msk_and_hpc3_pipe_pkg::*;
#(
    parameter int D          = 2,
    parameter int HAVE_INNER = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en_i,
    input  logic [D-1:0]          a_i,
    input  logic [D-1:0]          b_i,
    input  logic [hpc3rnd(D)-1:0] r_i,
    output logic [D-1:0]          out_o
);
    localparam int NP = npairs(D);

    // Diagonal entries stay zero, so the XOR tree may fold them in harmlessly.
    logic [D-1:0][D-1:0] u_q, u_d;
    logic [D-1:0][D-1:0] v_q, v_d;
    logic [D-1:0]        a_q;
    logic [D-1:0]        aibi_q, aibi_d;

    always_comb begin
        u_d = '0;
        v_d = '0;
        for (int i = 0; i < D; i++) begin
            for (int j = 0; j < D; j++) begin
                if (i != j) begin
                    // r0/r1 indexed by the unordered pair: r_ij == r_ji.
                    u_d[i][j] = (~a_i[i] & r_i[pair_idx(i, j, D)]) ^ r_i[NP + pair_idx(i, j, D)];
                    v_d[i][j] = b_i[j] ^ r_i[pair_idx(i, j, D)];
                end
            end
        end
        aibi_d = (HAVE_INNER != 0) ? (a_i & b_i) : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            u_q    <= '0;
            v_q    <= '0;
            a_q    <= '0;
            aibi_q <= '0;
        end else if (en_i) begin
            u_q    <= u_d;
            v_q    <= v_d;
            a_q    <= a_i;
            aibi_q <= aibi_d;
        end
    end

    for (genvar gi = 0; gi < D; gi++) begin : g_out
        assign out_o[gi] = (^(u_q[gi] ^ ({D{a_q[gi]}} & v_q[gi]))) ^ aibi_q[gi];
    end
endmodule

// File: rtl/msk_and_hpc3_pipe.sv
// ---------------------------------------------------------------------------
// msk_and_hpc3_pipe
// Purpose : W-lane HPC3 masked AND gadget with one output register stage.
//           A beat fires when data and randomness are both valid and the
//           output stage is free or being drained this cycle. Under
//           backpressure every register holds, so out stays bit-exact.
// Ports   : clk, rst_n (sync, active low), bus (msk_and_hpc3_pipe_if.slave:
//           in/rnd/out valid-ready handshakes, share-major ina/inb/out,
//           per-lane rnd slices).
// ---------------------------------------------------------------------------
module msk_and_hpc3_pipe
    import msk_and_hpc3_pipe_pkg::*;
#(
    parameter int D          = 2,
    parameter int W          = 8,
    parameter int HAVE_INNER = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    msk_and_hpc3_pipe_if.slave   bus
);
    localparam int RL = hpc3rnd(D);

    logic           out_valid_q, out_valid_d;
    logic           in_ready;
    logic           fire;
    logic [D*W-1:0] out_flat;

    assign in_ready = ~out_valid_q | bus.out_ready;
    assign fire     = bus.in_valid & bus.rnd_valid & in_ready;

    assign bus.in_ready  = in_ready;
    // Randomness is only taken alongside a beat we are able to accept.
    assign bus.rnd_ready = bus.in_valid & in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out       = out_flat;

    always_comb begin
        out_valid_d = out_valid_q;
        if (fire) begin
            out_valid_d = 1'b1;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
        end
    end

    // Regroup share-major buses into per-lane share vectors and back.
    for (genvar gi = 0; gi < W; gi++) begin : g_lane
        logic [D-1:0] a_lane;
        logic [D-1:0] b_lane;
        logic [D-1:0] o_lane;

        for (genvar si = 0; si < D; si++) begin : g_share
            assign a_lane[si]         = bus.ina[si*W + gi];
            assign b_lane[si]         = bus.inb[si*W + gi];
            assign out_flat[si*W + gi] = o_lane[si];
        end

        msk_and_hpc3_lane #(
            .D          (D),
            .HAVE_INNER (HAVE_INNER)
        ) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .en_i  (fire),
            .a_i   (a_lane),
            .b_i   (b_lane),
            .r_i   (bus.rnd[gi*RL +: RL]),
            .out_o (o_lane)
        );
    end
endmodule

// File: tb/tb_msk_and_hpc3_pipe.sv
module tb_msk_and_hpc3_pipe;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    msk_and_hpc3_pipe_if #(.D(2), .W(4)) if0 ();
    msk_and_hpc3_pipe_if #(.D(3), .W(4)) if1 ();

    msk_and_hpc3_pipe #(.D(2), .W(4), .HAVE_INNER(1)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if0.slave)
    );

    msk_and_hpc3_pipe #(.D(3), .W(4), .HAVE_INNER(0)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] rnd4();
        int unsigned x;
        x = $urandom;
        return x[3:0];
    endfunction

    function automatic logic [7:0] rnd8();
        int unsigned x;
        x = $urandom;
        return x[7:0];
    endfunction

    function automatic logic [23:0] rnd24();
        int unsigned x;
        x = $urandom;
        return x[23:0];
    endfunction

    function automatic logic [7:0] share2(input logic [3:0] v);
        logic [3:0] m;
        m = rnd4();
        return {v ^ m, m};
    endfunction

    function automatic logic [11:0] share3(input logic [3:0] v);
        logic [3:0] m0;
        logic [3:0] m1;
        m0 = rnd4();
        m1 = rnd4();
        return {v ^ m0 ^ m1, m1, m0};
    endfunction

    function automatic logic [3:0] unmask2(input logic [7:0] v);
        return v[3:0] ^ v[7:4];
    endfunction

    function automatic logic [3:0] unmask3(input logic [11:0] v);
        return v[3:0] ^ v[7:4] ^ v[11:8];
    endfunction

    // Exact d=2 output shares from the HPC3 equations:
    // out_i = a_i&b_j ^ r0 ^ r1 ^ a_i&b_i, with r0=rnd[2b], r1=rnd[2b+1].
    function automatic logic [7:0] exp2(input logic [7:0] as, input logic [7:0] bs, input logic [7:0] r);
        logic [7:0] o;
        o = '0;
        for (int b = 0; b < 4; b++) begin
            o[b]     = (as[b] & bs[4+b]) ^ r[2*b] ^ r[2*b+1] ^ (as[b] & bs[b]);
            o[4 + b] = (as[4+b] & bs[b]) ^ r[2*b] ^ r[2*b+1] ^ (as[4+b] & bs[4+b]);
        end
        return o;
    endfunction

    task automatic drive0(input logic [3:0] a, input logic [3:0] b, input logic iv, input logic rv);
        if0.ina       = share2(a);
        if0.inb       = share2(b);
        if0.rnd       = rnd8();
        if0.in_valid  = iv;
        if0.rnd_valid = rv;
    endtask

    initial begin
        logic [7:0]  e;
        logic [7:0]  sa [16];
        logic [7:0]  sb [16];
        logic [7:0]  sr [16];
        logic [3:0]  a;
        logic [3:0]  b;
        logic [3:0]  inner;
        logic [11:0] as3;
        logic [11:0] bs3;

        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        if0.in_valid = 1'b0; if0.rnd_valid = 1'b0; if0.out_ready = 1'b1;
        if0.ina = '0; if0.inb = '0; if0.rnd = '0;
        if1.in_valid = 1'b0; if1.rnd_valid = 1'b0; if1.out_ready = 1'b1;
        if1.ina = '0; if1.inb = '0; if1.rnd = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid0", 32'(if0.out_valid), 32'd0);
        check("rst_out0", 32'(if0.out), 32'd0);
        check("rst_out_valid1", 32'(if1.out_valid), 32'd0);
        if0.out_ready = 1'b0;
        #1;
        check("rst_in_ready", 32'(if0.in_ready), 32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_in_ready", 32'(if0.in_ready), 32'd1);

        // Basic: a=0xA, b=0xC -> 0x8, one cycle latency
        if0.out_ready = 1'b1;
        drive0(4'hA, 4'hC, 1'b1, 1'b1);
        e = exp2(if0.ina, if0.inb, if0.rnd);
        #1;
        check("basic_in_ready", 32'(if0.in_ready), 32'd1);
        check("basic_rnd_ready", 32'(if0.rnd_ready), 32'd1);
        @(posedge clk); #1;
        if0.in_valid = 1'b0; if0.rnd_valid = 1'b0;
        check("basic_out_valid", 32'(if0.out_valid), 32'd1);
        check("basic_unmask", 32'(unmask2(if0.out)), 32'h8);
        check("basic_shares", 32'(if0.out), 32'(e));
        @(posedge clk); #1;
        check("basic_drain", 32'(if0.out_valid), 32'd0);

        // Stall: beat 0x5&0x7 held 5 cycles while 0xF&0xF waits
        if0.out_ready = 1'b0;
        drive0(4'h5, 4'h7, 1'b1, 1'b1);
        e = exp2(if0.ina, if0.inb, if0.rnd);
        #1;
        check("stall_first_in_ready", 32'(if0.in_ready), 32'd1);
        @(posedge clk); #1;
        drive0(4'hF, 4'hF, 1'b1, 1'b1);
        #1;
        for (int k = 0; k < 5; k++) begin
            check("stall_out_valid", 32'(if0.out_valid), 32'd1);
            check("stall_out_exact", 32'(if0.out), 32'(e));
            check("stall_unmask", 32'(unmask2(if0.out)), 32'h5);
            check("stall_in_ready", 32'(if0.in_ready), 32'd0);
            check("stall_rnd_ready", 32'(if0.rnd_ready), 32'd0);
            @(posedge clk); #1;
        end
        e = exp2(if0.ina, if0.inb, if0.rnd);
        if0.out_ready = 1'b1;
        #1;
        check("release_in_ready", 32'(if0.in_ready), 32'd1);
        @(posedge clk); #1;
        if0.in_valid = 1'b0; if0.rnd_valid = 1'b0;
        check("release_out_valid", 32'(if0.out_valid), 32'd1);
        check("release_shares", 32'(if0.out), 32'(e));
        check("release_unmask", 32'(unmask2(if0.out)), 32'hF);
        @(posedge clk); #1;
        check("release_drain", 32'(if0.out_valid), 32'd0);

        // Randomness starved for 3 cycles
        drive0(4'h6, 4'hB, 1'b1, 1'b0);
        e = exp2(if0.ina, if0.inb, if0.rnd);
        #1;
        for (int k = 0; k < 3; k++) begin
            check("starve_rnd_ready", 32'(if0.rnd_ready), 32'd1);
            @(posedge clk); #1;
            check("starve_no_fire", 32'(if0.out_valid), 32'd0);
        end
        if0.rnd_valid = 1'b1;
        @(posedge clk); #1;
        if0.in_valid = 1'b0; if0.rnd_valid = 1'b0;
        check("starve_out_valid", 32'(if0.out_valid), 32'd1);
        check("starve_shares", 32'(if0.out), 32'(e));
        check("starve_unmask", 32'(unmask2(if0.out)), 32'h2);
        @(posedge clk); #1;

        // Streaming 16 beats back-to-back
        for (int k = 0; k < 16; k++) begin
            a = 4'(k);
            b = 4'(15 - k);
            sa[k] = share2(a);
            sb[k] = share2(b);
            sr[k] = rnd8();
        end
        for (int k = 0; k < 16; k++) begin
            if0.ina = sa[k]; if0.inb = sb[k]; if0.rnd = sr[k];
            if0.in_valid = 1'b1; if0.rnd_valid = 1'b1;
            #1;
            check("stream_in_ready", 32'(if0.in_ready), 32'd1);
            @(posedge clk); #1;
            check("stream_out_valid", 32'(if0.out_valid), 32'd1);
            check("stream_shares", 32'(if0.out), 32'(exp2(sa[k], sb[k], sr[k])));
            check("stream_unmask", 32'(unmask2(if0.out)), 32'(4'(k) & 4'(15 - k)));
        end
        if0.in_valid = 1'b0; if0.rnd_valid = 1'b0;
        @(posedge clk); #1;
        check("stream_drain", 32'(if0.out_valid), 32'd0);

        // Reset in the middle of a stall
        if0.out_ready = 1'b0;
        drive0(4'h9, 4'h9, 1'b1, 1'b1);
        @(posedge clk); #1;
        if0.in_valid = 1'b0; if0.rnd_valid = 1'b0;
        check("rststall_valid", 32'(if0.out_valid), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("rststall_out_valid", 32'(if0.out_valid), 32'd0);
        check("rststall_out", 32'(if0.out), 32'd0);
        #1;
        check("rststall_in_ready", 32'(if0.in_ready), 32'd1);
        if0.out_ready = 1'b1;
        drive0(4'h3, 4'h6, 1'b1, 1'b1);
        e = exp2(if0.ina, if0.inb, if0.rnd);
        @(posedge clk); #1;
        if0.in_valid = 1'b0; if0.rnd_valid = 1'b0;
        check("rststall_next_valid", 32'(if0.out_valid), 32'd1);
        check("rststall_next_shares", 32'(if0.out), 32'(e));
        check("rststall_next_unmask", 32'(unmask2(if0.out)), 32'h2);

        // d=3, cross-domain terms only: 1000 random beats
        for (int k = 0; k < 1000; k++) begin
            a = rnd4();
            b = rnd4();
            as3 = share3(a);
            bs3 = share3(b);
            inner = (as3[3:0] & bs3[3:0]) ^ (as3[7:4] & bs3[7:4]) ^ (as3[11:8] & bs3[11:8]);
            if1.ina = as3; if1.inb = bs3; if1.rnd = rnd24();
            if1.in_valid = 1'b1; if1.rnd_valid = 1'b1;
            @(posedge clk); #1;
            check("d3_out_valid", 32'(if1.out_valid), 32'd1);
            check("d3_unmask", 32'(unmask3(if1.out)), 32'((a & b) ^ inner));
        end
        if1.in_valid = 1'b0; if1.rnd_valid = 1'b0;
        @(posedge clk); #1;
        check("d3_drain", 32'(if1.out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
